load_store_unit: RTL and testbench

- Sits between the CPU datapath and the word-organised data memory.
- Converts byte/half/word load-store requests into word-aligned memory accesses: aligned address, byte enables, lane-shifted write data.
- Extracts and sign- or zero-extends load data from the memory's combinational read port.
- Accesses that cross a word boundary are split into two memory cycles, and the CPU is stalled for one cycle.

---
 rtl/load_store_unit_if.sv | 34 +++
 rtl/load_store_unit.sv | 145 ++++++++++++++
 tb/tb_load_store_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - CPU request / data-memory port bundle for load_store_unit.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  stall;
  logic [31:0]           load_data;
  logic                  load_valid;
  logic                  access_err;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [31:0]           mem_write_data;
  logic [3:0]            mem_byte_enable;
  logic                  mem_write_enable;
  logic [31:0]           mem_read_data;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_read_data,
    output stall, load_data, load_valid, access_err,
    output mem_address, mem_write_data, mem_byte_enable, mem_write_enable
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output mem_read_data,
    input  stall, load_data, load_valid, access_err,
    input  mem_address, mem_write_data, mem_byte_enable, mem_write_enable
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store to word memory with lane shifting and extension.
// Macro LSU_MISALIGN_SPLIT_EN: split word-crossing accesses over two cycles; otherwise flag access_err.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  load_store_unit_if.slave  bus
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic {IDLE, SECOND} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  unsigned_q;
  logic                  we_q;
  logic [31:0]           wdata_q;
  logic [31:0]           low_q;
  logic                  latch_en;

  logic [1:0]  off;
  logic [2:0]  nbytes;
  logic [3:0]  mask;
  logic [7:0]  be_wide;
  logic        crossing;
  logic [2:0]  rem;
  logic [31:0] low_d;

  function automatic logic [2:0] size_bytes(input logic [1:0] s);
    case (s)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] size_mask(input logic [1:0] s);
    case (s)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] s,
                                         input logic uns);
    case (s)
      2'b00:   return uns ? {24'd0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
      2'b01:   return uns ? {16'd0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  assign off      = bus.req_addr[1:0];
  assign nbytes   = size_bytes(bus.req_size);
  assign mask     = size_mask(bus.req_size);
  assign be_wide  = {4'd0, mask} << off;
  assign crossing = ({1'b0, off} + nbytes) > 3'd4;
  // Second-half shift is the number of bytes already handled in the low word.
  assign rem      = 3'd4 - {1'b0, addr_q[1:0]};
  assign low_d    = bus.mem_read_data >> {off, 3'b000};

  always_comb begin
    state_d              = state_q;
    latch_en             = 1'b0;
    bus.stall            = 1'b0;
    bus.load_data        = 32'd0;
    bus.load_valid       = 1'b0;
    bus.access_err       = 1'b0;
    bus.mem_address      = '0;
    bus.mem_write_data   = 32'd0;
    bus.mem_byte_enable  = 4'd0;
    bus.mem_write_enable = 1'b0;

    if (!rst_n) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            if (bus.req_size == 2'b11 || (crossing && !SPLIT_EN)) begin
              bus.access_err = 1'b1;
            end else begin
              bus.mem_address      = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
              bus.mem_byte_enable  = be_wide[3:0];
              bus.mem_write_data   = bus.req_wdata << {off, 3'b000};
              bus.mem_write_enable = bus.req_we;
              if (crossing) begin
                bus.stall = 1'b1;
                latch_en  = 1'b1;
                state_d   = SECOND;
              end else if (!bus.req_we) begin
                bus.load_valid = 1'b1;
                bus.load_data  = extend(low_d, bus.req_size, bus.req_unsigned);
              end
            end
          end
        end
        SECOND: begin
          bus.mem_address      = {addr_q[ADDR_WIDTH-1:2], 2'b00} + ADDR_WIDTH'(4);
          bus.mem_byte_enable  = size_mask(size_q) >> rem;
          bus.mem_write_data   = wdata_q >> {rem, 3'b000};
          bus.mem_write_enable = we_q;
          if (!we_q) begin
            bus.load_valid = 1'b1;
            bus.load_data  = extend(low_q | (bus.mem_read_data << {rem, 3'b000}),
                                    size_q, unsigned_q);
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      size_q     <= 2'd0;
      unsigned_q <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= 32'd0;
      low_q      <= 32'd0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        addr_q     <= bus.req_addr;
        size_q     <= bus.req_size;
        unsigned_q <= bus.req_unsigned;
        we_q       <= bus.req_we;
        wdata_q    <= bus.req_wdata;
        low_q      <= low_d;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a 16-word memory model.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_WIDTH(32)) bus ();

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [16];
  logic        pl_en;
  logic [3:0]  pl_idx;
  logic [31:0] pl_data;

  always_comb bus.mem_read_data = mem[bus.mem_address[5:2]];

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_idx] <= pl_data;
    end else if (bus.mem_write_enable) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_byte_enable[b])
          mem[bus.mem_address[5:2]][8*b +: 8] <= bus.mem_write_data[8*b +: 8];
    end
  end

  typedef struct {
    string       name;
    logic        stall, lv, err, we;
    logic [31:0] ld, addr, wd;
    logic [3:0]  be;
    bit          chk_addr;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic expect_out(input string nm, input logic st, input logic lv, input logic [31:0] ld,
                            input logic err, input logic we, input logic [31:0] addr,
                            input logic [3:0] be, input logic [31:0] wd, input bit ca);
    exp_t e;
    e.name = nm; e.stall = st; e.lv = lv; e.ld = ld; e.err = err; e.we = we;
    e.addr = addr; e.be = be; e.wd = wd; e.chk_addr = ca;
    q.push_back(e);
  endtask

  // Monitor: any visible DUT activity must match the next queued expectation.
  always @(negedge clk) begin
    if (bus.stall || bus.load_valid || bus.access_err || bus.mem_write_enable ||
        bus.mem_byte_enable != 4'd0) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: st=%b lv=%b err=%b we=%b be=%b addr=%h, required no activity",
                 bus.stall, bus.load_valid, bus.access_err, bus.mem_write_enable,
                 bus.mem_byte_enable, bus.mem_address);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (bus.stall !== e.stall || bus.load_valid !== e.lv || bus.access_err !== e.err ||
            bus.mem_write_enable !== e.we || bus.mem_byte_enable !== e.be ||
            (e.lv && bus.load_data !== e.ld) || (e.we && bus.mem_write_data !== e.wd) ||
            (e.chk_addr && bus.mem_address !== e.addr)) begin
          n_fail++;
          $display("FAIL %s: got st=%b lv=%b ld=%h err=%b we=%b addr=%h be=%b wd=%h; required st=%b lv=%b ld=%h err=%b we=%b addr=%h be=%b wd=%h",
                   e.name, bus.stall, bus.load_valid, bus.load_data, bus.access_err,
                   bus.mem_write_enable, bus.mem_address, bus.mem_byte_enable, bus.mem_write_data,
                   e.stall, e.lv, e.ld, e.err, e.we, e.addr, e.be, e.wd);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] d);
    pl_en = 1'b1; pl_idx = idx; pl_data = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic req(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
    bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = wd;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
  endtask

  initial begin
    rst_n = 1'b0; pl_en = 1'b0; pl_idx = 4'd0; pl_data = 32'd0;
    idle();
    step();
    // Request presented during reset must be suppressed.
    req(1'b1, 2'b10, 1'b0, 32'h10, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("reset_outputs", {56'd0, bus.stall, bus.load_valid, bus.access_err,
                          bus.mem_write_enable, bus.mem_byte_enable}, 64'd0);
    chk("reset_addr", {32'd0, bus.mem_address}, 64'd0);
    step();
    rst_n = 1'b1;
    idle();
    @(negedge clk);
    chk("idle_outputs", {bus.load_data, 24'd0, bus.stall, bus.load_valid, bus.access_err,
                         bus.mem_write_enable, bus.mem_byte_enable}, 64'd0);
    step();
    preload(4'd4, 32'h8899_AABB);

    req(1'b0, 2'b00, 1'b0, 32'h13, 32'd0);
    expect_out("lb_13", 0, 1, 32'hFFFF_FF88, 0, 0, 32'h10, 4'b1000, 0, 1); step();
    req(1'b0, 2'b00, 1'b1, 32'h13, 32'd0);
    expect_out("lbu_13", 0, 1, 32'h0000_0088, 0, 0, 32'h10, 4'b1000, 0, 1); step();
    req(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_1234);
    expect_out("sh_12", 0, 0, 0, 0, 1, 32'h10, 4'b1100, 32'h1234_0000, 1); step();
    req(1'b0, 2'b01, 1'b0, 32'h12, 32'd0);
    expect_out("lh_12", 0, 1, 32'h0000_1234, 0, 0, 32'h10, 4'b1100, 0, 1); step();
    req(1'b0, 2'b01, 1'b0, 32'h10, 32'd0);
    expect_out("lh_10", 0, 1, 32'hFFFF_AABB, 0, 0, 32'h10, 4'b0011, 0, 1); step();
    req(1'b1, 2'b11, 1'b0, 32'h10, 32'hDEAD_BEEF);
    expect_out("illegal_size", 0, 0, 0, 1, 0, 0, 4'b0000, 0, 0); step();
    req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    expect_out("lw_10", 0, 1, 32'h1234_AABB, 0, 0, 32'h10, 4'b1111, 0, 1); step();

    idle();
    preload(4'd4, 32'h4433_2211);
    preload(4'd5, 32'h8877_6655);
    preload(4'd0, 32'd0);
    preload(4'd1, 32'd0);

    req(1'b0, 2'b10, 1'b0, 32'h13, 32'd0);
`ifdef LSU_MISALIGN_SPLIT_EN
    expect_out("lw_13_c0", 1, 0, 0, 0, 0, 32'h10, 4'b1000, 0, 1); step();
    expect_out("lw_13_c1", 0, 1, 32'h7766_5544, 0, 0, 32'h14, 4'b0111, 0, 1); step();
`else
    expect_out("lw_13_err", 0, 0, 0, 1, 0, 0, 4'b0000, 0, 0); step();
`endif

    req(1'b1, 2'b10, 1'b0, 32'h03, 32'hDDCC_BBAA);
`ifdef LSU_MISALIGN_SPLIT_EN
    expect_out("sw_03_c0", 1, 0, 0, 0, 1, 32'h00, 4'b1000, 32'hAA00_0000, 1); step();
    expect_out("sw_03_c1", 0, 0, 0, 0, 1, 32'h04, 4'b0111, 32'h00DD_CCBB, 1); step();
    req(1'b0, 2'b10, 1'b0, 32'h00, 32'd0);
    expect_out("lw_00", 0, 1, 32'hAA00_0000, 0, 0, 32'h00, 4'b1111, 0, 1); step();
    req(1'b0, 2'b10, 1'b0, 32'h04, 32'd0);
    expect_out("lw_04", 0, 1, 32'h00DD_CCBB, 0, 0, 32'h04, 4'b1111, 0, 1); step();
    req(1'b0, 2'b01, 1'b0, 32'h03, 32'd0);
    expect_out("lh_03_c0", 1, 0, 0, 0, 0, 32'h00, 4'b1000, 0, 1); step();
    expect_out("lh_03_c1", 0, 1, 32'hFFFF_BBAA, 0, 0, 32'h04, 4'b0001, 0, 1); step();
`else
    expect_out("sw_03_err", 0, 0, 0, 1, 0, 0, 4'b0000, 0, 0); step();
    req(1'b0, 2'b10, 1'b0, 32'h00, 32'd0);
    expect_out("lw_00", 0, 1, 32'h0000_0000, 0, 0, 32'h00, 4'b1111, 0, 1); step();
    req(1'b0, 2'b10, 1'b0, 32'h04, 32'd0);
    expect_out("lw_04", 0, 1, 32'h0000_0000, 0, 0, 32'h04, 4'b1111, 0, 1); step();
`endif

    idle();
    preload(4'd15, 32'h1122_3344);
    preload(4'd0, 32'h5566_7788);
    req(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'd0);
`ifdef LSU_MISALIGN_SPLIT_EN
    expect_out("lw_wrap_c0", 1, 0, 0, 0, 0, 32'hFFFF_FFFC, 4'b1100, 0, 1); step();
    expect_out("lw_wrap_c1", 0, 1, 32'h7788_1122, 0, 0, 32'h0000_0000, 4'b0011, 0, 1); step();
`else
    expect_out("lw_wrap_err", 0, 0, 0, 1, 0, 0, 4'b0000, 0, 0); step();
`endif

    // Reset lands on the second half of a split store.
    req(1'b1, 2'b10, 1'b0, 32'h07, 32'h1122_3344);
`ifdef LSU_MISALIGN_SPLIT_EN
    expect_out("sw_07_c0", 1, 0, 0, 0, 1, 32'h04, 4'b1000, 32'h4400_0000, 1); step();
`else
    expect_out("sw_07_err", 0, 0, 0, 1, 0, 0, 4'b0000, 0, 0); step();
`endif
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_second_we", {63'd0, bus.mem_write_enable}, 64'd0);
    chk("rst_second_be", {60'd0, bus.mem_byte_enable}, 64'd0);
    step();
    rst_n = 1'b1;
    req(1'b1, 2'b10, 1'b0, 32'h08, 32'hCAFE_F00D);
    expect_out("sw_08_after_rst", 0, 0, 0, 0, 1, 32'h08, 4'b1111, 32'hCAFE_F00D, 1); step();
    req(1'b0, 2'b10, 1'b0, 32'h08, 32'd0);
    expect_out("lw_08", 0, 1, 32'hCAFE_F00D, 0, 0, 32'h08, 4'b1111, 0, 1); step();
    idle();
    repeat (3) step();

    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
